// File: rtl/branch_resolve_unit_if.sv
// EX-to-fetch bundle for the branch resolve unit: EX operands in, redirect/training out.
// Build with BRU_PERF_CNT_EN to expose the branch/mispredict counters.
interface branch_resolve_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              stall;
  logic              ex_valid;
  logic [5:0]        ex_opcode;
  logic [15:0]       ex_offset;
  logic [ADDR_W-1:0] ex_pc_1;
  logic [31:0]       ex_rs_data;
  logic [31:0]       ex_rt_data;
  logic              ex_pred_taken;

  logic              changeFlow;
  logic [ADDR_W-1:0] jb_addr;
  logic              taken;
  logic              not_taken;
  logic              flush;
  logic              busy;
`ifdef BRU_PERF_CNT_EN
  logic [31:0]       branch_cnt;
  logic [31:0]       mispred_cnt;

  // Producer side: the resolve unit itself.
  modport master (
    input  stall, ex_valid, ex_opcode, ex_offset, ex_pc_1, ex_rs_data, ex_rt_data,
           ex_pred_taken,
    output changeFlow, jb_addr, taken, not_taken, flush, busy, branch_cnt, mispred_cnt
  );

  modport slave (
    output stall, ex_valid, ex_opcode, ex_offset, ex_pc_1, ex_rs_data, ex_rt_data,
           ex_pred_taken,
    input  changeFlow, jb_addr, taken, not_taken, flush, busy, branch_cnt, mispred_cnt
  );
`else
  // Producer side: the resolve unit itself.
  modport master (
    input  stall, ex_valid, ex_opcode, ex_offset, ex_pc_1, ex_rs_data, ex_rt_data,
           ex_pred_taken,
    output changeFlow, jb_addr, taken, not_taken, flush, busy
  );

  modport slave (
    output stall, ex_valid, ex_opcode, ex_offset, ex_pc_1, ex_rs_data, ex_rt_data,
           ex_pred_taken,
    input  changeFlow, jb_addr, taken, not_taken, flush, busy
  );
`endif
endinterface

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: evaluates the condition, trains the predictor and redirects
// fetch on a mispredict, then squashes for SQUASH_CYCLES. Optional counters: BRU_PERF_CNT_EN.
module branch_resolve_unit #(
  parameter int unsigned SQUASH_CYCLES = 2,
  parameter int unsigned ADDR_W        = 32
) (
  input logic                   clk,
  input logic                   rst,
  branch_resolve_unit_if.master bru
);

  localparam logic [5:0] OpBeq  = 6'h13;
  localparam logic [5:0] OpBne  = 6'h14;
  localparam logic [5:0] OpBlt  = 6'h15;
  localparam logic [5:0] OpBge  = 6'h16;
  localparam logic [5:0] OpBltu = 6'h17;
  localparam logic [5:0] OpBgeu = 6'h18;
  localparam logic [5:0] OpBez  = 6'h19;

  typedef enum logic [0:0] {StIdle, StRecover} state_e;

  state_e            state_q;
  logic [3:0]        squash_q;
  logic              change_q;
  logic [ADDR_W-1:0] jb_addr_q;
  logic              taken_q;
  logic              not_taken_q;
  logic              flush_q;
  logic              busy_q;

  logic              is_branch;
  logic              cond;
  logic [ADDR_W-1:0] target;
  logic              sample;
  logic              mispred;

  always_comb begin
    is_branch = 1'b1;
    cond      = 1'b0;
    case (bru.ex_opcode)
      OpBeq:   cond = (bru.ex_rs_data == bru.ex_rt_data);
      OpBne:   cond = (bru.ex_rs_data != bru.ex_rt_data);
      OpBlt:   cond = ($signed(bru.ex_rs_data) < $signed(bru.ex_rt_data));
      OpBge:   cond = ($signed(bru.ex_rs_data) >= $signed(bru.ex_rt_data));
      OpBltu:  cond = (bru.ex_rs_data < bru.ex_rt_data);
      OpBgeu:  cond = (bru.ex_rs_data >= bru.ex_rt_data);
      OpBez:   cond = (bru.ex_rs_data == 32'd0);
      default: is_branch = 1'b0;
    endcase
  end

  // Offset is a signed word offset; overflow past the top of the address space wraps.
  assign target  = bru.ex_pc_1 + ADDR_W'($signed(bru.ex_offset));
  assign sample  = (state_q == StIdle) && !bru.stall && bru.ex_valid && is_branch;
  assign mispred = sample && (bru.ex_pred_taken != cond);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      squash_q    <= 4'd0;
      change_q    <= 1'b0;
      jb_addr_q   <= '0;
      taken_q     <= 1'b0;
      not_taken_q <= 1'b0;
      flush_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      taken_q     <= sample && cond;
      not_taken_q <= sample && !cond;
      change_q    <= mispred;
      if (mispred) begin
        jb_addr_q <= cond ? target : bru.ex_pc_1;
      end
      case (state_q)
        StIdle: begin
          if (mispred) begin
            state_q  <= StRecover;
            squash_q <= 4'(SQUASH_CYCLES);
            flush_q  <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        StRecover: begin
          // Counter runs through stalls so the squash window is a fixed length.
          if (squash_q <= 4'd1) begin
            state_q  <= StIdle;
            squash_q <= 4'd0;
            flush_q  <= 1'b0;
            busy_q   <= 1'b0;
          end else begin
            squash_q <= squash_q - 4'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bru.changeFlow = change_q;
  assign bru.jb_addr    = jb_addr_q;
  assign bru.taken      = taken_q;
  assign bru.not_taken  = not_taken_q;
  assign bru.flush      = flush_q;
  assign bru.busy       = busy_q;

`ifdef BRU_PERF_CNT_EN
  logic [31:0] branch_cnt_q;
  logic [31:0] mispred_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q  <= 32'd0;
      mispred_cnt_q <= 32'd0;
    end else begin
      if (sample && (branch_cnt_q != 32'hFFFF_FFFF)) begin
        branch_cnt_q <= branch_cnt_q + 32'd1;
      end
      if (mispred && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
        mispred_cnt_q <= mispred_cnt_q + 32'd1;
      end
    end
  end

  assign bru.branch_cnt  = branch_cnt_q;
  assign bru.mispred_cnt = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed literal checks plus randomized traffic compared
// every cycle against a behavioural model of the branch rules and squash window.
module tb_branch_resolve_unit;

  localparam int unsigned SQ = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_resolve_unit_if #(.ADDR_W(32)) bus ();

  branch_resolve_unit #(.SQUASH_CYCLES(SQ), .ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bru (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Model state: expected outputs for the current cycle.
  logic        m_cf, m_taken, m_nt;
  logic [31:0] m_jb;
  int          m_left = 0;  // squash cycles still to show, including the current one
  longint      m_bcnt, m_mcnt;

  initial begin
    m_cf = 0; m_taken = 0; m_nt = 0; m_jb = 0; m_bcnt = 0; m_mcnt = 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns {is_branch, condition}.
  function automatic logic [1:0] resolve(input logic [5:0] op, input logic [31:0] rs,
                                          input logic [31:0] rt);
    longint srs, srt;
    srs = longint'($signed(rs));
    srt = longint'($signed(rt));
    case (op)
      6'h13: return {1'b1, rs == rt};
      6'h14: return {1'b1, rs != rt};
      6'h15: return {1'b1, srs < srt};
      6'h16: return {1'b1, srs >= srt};
      6'h17: return {1'b1, {32'd0, rs} < {32'd0, rt}};
      6'h18: return {1'b1, {32'd0, rs} >= {32'd0, rt}};
      6'h19: return {1'b1, rs == 32'd0};
      default: return 2'b00;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [1:0]  rb;
    logic        smp, mis;
    int          left;
    logic [31:0] tgt;
    if (rst) begin
      m_cf <= 0; m_taken <= 0; m_nt <= 0; m_jb <= 0; m_left <= 0; m_bcnt <= 0; m_mcnt <= 0;
    end else begin
      left = (m_left > 0) ? m_left - 1 : 0;
      rb   = resolve(bus.ex_opcode, bus.ex_rs_data, bus.ex_rt_data);
      smp  = (m_left == 0) && !bus.stall && bus.ex_valid && rb[1];
      mis  = smp && (bus.ex_pred_taken != rb[0]);
      tgt  = 32'(longint'(bus.ex_pc_1) + longint'($signed(bus.ex_offset)));
      m_taken <= smp && rb[0];
      m_nt    <= smp && !rb[0];
      m_cf    <= mis;
      if (mis) begin
        m_jb <= rb[0] ? tgt : bus.ex_pc_1;
        left = SQ;
      end
      m_left <= left;
      if (smp && m_bcnt < 64'hFFFF_FFFF) m_bcnt <= m_bcnt + 1;
      if (mis && m_mcnt < 64'hFFFF_FFFF) m_mcnt <= m_mcnt + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m.changeFlow", {31'd0, bus.changeFlow}, {31'd0, m_cf});
      chk("m.jb_addr", bus.jb_addr, m_jb);
      chk("m.taken", {31'd0, bus.taken}, {31'd0, m_taken});
      chk("m.not_taken", {31'd0, bus.not_taken}, {31'd0, m_nt});
      chk("m.flush", {31'd0, bus.flush}, {31'd0, m_left > 0});
      chk("m.busy", {31'd0, bus.busy}, {31'd0, m_left > 0});
`ifdef BRU_PERF_CNT_EN
      chk("m.branch_cnt", bus.branch_cnt, 32'(m_bcnt));
      chk("m.mispred_cnt", bus.mispred_cnt, 32'(m_mcnt));
`endif
    end
  end

  task automatic drv(input logic v, input logic [5:0] op, input logic [31:0] rs,
                     input logic [31:0] rt, input logic [31:0] pc, input logic [15:0] off,
                     input logic pred);
    bus.ex_valid      = v;
    bus.ex_opcode     = op;
    bus.ex_rs_data    = rs;
    bus.ex_rt_data    = rt;
    bus.ex_pc_1       = pc;
    bus.ex_offset     = off;
    bus.ex_pred_taken = pred;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    bus.stall = 1'b0;
    drv(0, 6'h00, 0, 0, 0, 0, 0);
    rst = 1'b1;
    cyc(); cyc();
    chk("rst.changeFlow", {31'd0, bus.changeFlow}, 32'd0);
    chk("rst.jb_addr", bus.jb_addr, 32'd0);
    chk("rst.taken", {31'd0, bus.taken}, 32'd0);
    chk("rst.not_taken", {31'd0, bus.not_taken}, 32'd0);
    chk("rst.flush", {31'd0, bus.flush}, 32'd0);
    chk("rst.busy", {31'd0, bus.busy}, 32'd0);
    chk_en = 1'b1;
    rst = 1'b0;

    // BEQ predicted taken correctly
    drv(1, 6'h13, 5, 5, 32'h10, 16'h0004, 1); cyc();
    chk("beq.taken", {31'd0, bus.taken}, 32'd1);
    chk("beq.changeFlow", {31'd0, bus.changeFlow}, 32'd0);
    chk("beq.flush", {31'd0, bus.flush}, 32'd0);
    drv(0, 6'h00, 0, 0, 0, 0, 0); cyc();
    chk("beq.pulse_end", {31'd0, bus.taken}, 32'd0);

    // BNE mispredicted taken; BEQ during the squash window is ignored
    drv(1, 6'h14, 7, 7, 32'h20, 16'h0000, 1); cyc();
    chk("bne.not_taken", {31'd0, bus.not_taken}, 32'd1);
    chk("bne.changeFlow", {31'd0, bus.changeFlow}, 32'd1);
    chk("bne.jb_addr", bus.jb_addr, 32'h20);
    chk("bne.flush1", {31'd0, bus.flush}, 32'd1);
    drv(1, 6'h13, 5, 5, 32'h30, 16'h0000, 0); cyc();
    chk("bne.flush2", {31'd0, bus.flush}, 32'd1);
    chk("squash.no_taken", {31'd0, bus.taken}, 32'd0);
    drv(0, 6'h00, 0, 0, 0, 0, 0); cyc();
    chk("bne.flush_off", {31'd0, bus.flush}, 32'd0);
    chk("squash.no_taken2", {31'd0, bus.taken}, 32'd0);

    // BLT signed -1 < 1, predicted not taken
    drv(1, 6'h15, 32'hFFFF_FFFF, 1, 32'h8, 16'hFFFC, 0); cyc();
    chk("blt.taken", {31'd0, bus.taken}, 32'd1);
    chk("blt.changeFlow", {31'd0, bus.changeFlow}, 32'd1);
    chk("blt.jb_addr", bus.jb_addr, 32'h4);
    drv(0, 6'h00, 0, 0, 0, 0, 0); cyc(); cyc();
    drv(1, 6'h17, 32'hFFFF_FFFF, 1, 32'h8, 16'hFFFC, 0); cyc();
    chk("bltu.not_taken", {31'd0, bus.not_taken}, 32'd1);
    chk("bltu.changeFlow", {31'd0, bus.changeFlow}, 32'd0);
    chk("bltu.jb_hold", bus.jb_addr, 32'h4);
    drv(0, 6'h00, 0, 0, 0, 0, 0); cyc();

    // Stalled mispredicting branch
    bus.stall = 1'b1;
    drv(1, 6'h14, 1, 2, 32'h100, 16'h0010, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall.taken", {31'd0, bus.taken}, 32'd0);
      chk("stall.changeFlow", {31'd0, bus.changeFlow}, 32'd0);
    end
    bus.stall = 1'b0; cyc();
    chk("unstall.taken", {31'd0, bus.taken}, 32'd1);
    chk("unstall.changeFlow", {31'd0, bus.changeFlow}, 32'd1);
    chk("unstall.jb_addr", bus.jb_addr, 32'h110);
    drv(0, 6'h00, 0, 0, 0, 0, 0); cyc();
    chk("unstall.single", {31'd0, bus.taken}, 32'd0);
    chk("unstall.cf_single", {31'd0, bus.changeFlow}, 32'd0);
    cyc();

    // Reset in the first recover cycle
    drv(1, 6'h13, 9, 9, 32'h40, 16'h0000, 0); cyc();
    chk("rrec.changeFlow", {31'd0, bus.changeFlow}, 32'd1);
    chk("rrec.flush", {31'd0, bus.flush}, 32'd1);
    drv(0, 6'h00, 0, 0, 0, 0, 0);
    rst = 1'b1; cyc();
    chk("rrec.flush_clr", {31'd0, bus.flush}, 32'd0);
    chk("rrec.busy_clr", {31'd0, bus.busy}, 32'd0);
    chk("rrec.jb_clr", bus.jb_addr, 32'd0);
    rst = 1'b0;

    // Three branches, last one mispredicts
    drv(1, 6'h13, 3, 3, 32'h0, 16'h0000, 1); cyc();
    drv(1, 6'h14, 1, 2, 32'h0, 16'h0000, 1); cyc();
    drv(1, 6'h19, 0, 5, 32'h0, 16'h0008, 0); cyc();
    drv(0, 6'h00, 0, 0, 0, 0, 0);
    chk("bez.jb_addr", bus.jb_addr, 32'h8);
`ifdef BRU_PERF_CNT_EN
    chk("perf.branch_cnt", bus.branch_cnt, 32'd3);
    chk("perf.mispred_cnt", bus.mispred_cnt, 32'd1);
`endif
    cyc(); cyc(); cyc();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rs, rt;
      rs = $urandom_range(0, 1) ? 32'($urandom_range(0, 3)) - 32'd1 : $urandom;
      rt = $urandom_range(0, 1) ? 32'($urandom_range(0, 3)) - 32'd1 : $urandom;
      rst       = ($urandom_range(0, 99) == 0);
      bus.stall = ($urandom_range(0, 3) == 0);
      drv($urandom_range(0, 3) != 0, 6'($urandom_range(6'h10, 6'h1B)), rs, rt, $urandom,
          16'($urandom), 1'($urandom_range(0, 1)));
      cyc();
    end

    rst = 1'b0;
    bus.stall = 1'b0;
    drv(0, 6'h00, 0, 0, 0, 0, 0);
    cyc(); cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
